sub_bytes_sched: RTL and testbench

SUB_BYTES_SCHED -- requirements
Module: sub_bytes_sched

---
 rtl/sub_bytes_sched.sv | 181 ++++++++++++++++++
 tb/tb_sub_bytes_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_sched.sv
// ---------------------------------------------------------------------------
// sub_bytes_sched
//   Shares a single AES forward S-box between two requesters: the state path
//   (16-byte SubBytes) and the key-expansion path (4-byte SubWord). The S-box
//   handles one byte per cycle, selected by the byte counter.
//
// Ports
//   CLK, RST_N        clock, asynchronous active-low reset
//   REQ_S / DIN_S     state request and 128-bit operand
//   GNT_S / DONE_S    state grant pulse (operand captured) / result-valid pulse
//   DOUT_S            128-bit substituted state
//   REQ_K / DIN_K     key request and 32-bit operand
//   GNT_K / DONE_K    key grant pulse / result-valid pulse
//   DOUT_K            32-bit substituted word
//   BUSY              high whenever the FSM is outside IDLE
//
// Parameter
//   KEY_PRIO          0 = round-robin on a tie, 1 = key requester always wins
// ---------------------------------------------------------------------------

// AES forward S-box, pure combinational lookup.
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   // Entry 0 sits in the most significant byte, so entry b lives at
   // bit offset (255 - b) * 8, i.e. {~b, 3'b000}.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign o_byte = SBOX_TABLE[{~i_byte, 3'b000} +: 8];
endmodule

// FSM states
//   state    | meaning
//   IDLE     | waiting; grants one requester when any REQ is high
//   RUN_S    | substituting state bytes 0..15, one per cycle
//   RUN_K    | substituting key bytes 0..3, one per cycle
//   DONE     | one-cycle DONE pulse for the requester just served
module sub_bytes_sched #(
   parameter bit KEY_PRIO = 1'b0
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         REQ_S,
   input  logic [127:0] DIN_S,
   output logic         GNT_S,
   output logic         DONE_S,
   output logic [127:0] DOUT_S,
   input  logic         REQ_K,
   input  logic [31:0]  DIN_K,
   output logic         GNT_K,
   output logic         DONE_K,
   output logic [31:0]  DOUT_K,
   output logic         BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN_S = 2'd1,
      ST_RUN_K = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [3:0]     r_cnt;
   logic           r_last_k;   // 1 = key was granted last / is being served
   logic           r_rdy;      // blocks grants until one edge after reset release
   logic [127:0]   r_op;
   logic [127:0]   r_dout_s;
   logic [31:0]    r_dout_k;

   logic           w_gnt_s;
   logic           w_gnt_k;
   logic           w_done_s;
   logic           w_done_k;
   logic           w_busy;
   logic [7:0]     w_sbox_in;
   logic [7:0]     w_sbox_out;

   assign w_sbox_in = r_op[{r_cnt, 3'b000} +: 8];

   aes_sbox u_sbox (
      .i_byte (w_sbox_in),
      .o_byte (w_sbox_out)
   );

   // state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_gnt_k)      w_state_nxt = ST_RUN_K;
            else if (w_gnt_s) w_state_nxt = ST_RUN_S;
         end
         ST_RUN_S: if (r_cnt == 4'd15) w_state_nxt = ST_DONE;
         ST_RUN_K: if (r_cnt == 4'd3)  w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // output logic; on a tie the key wins unless it was the last one granted
   // under round-robin
   always_comb begin
      w_gnt_k  = 1'b0;
      w_gnt_s  = 1'b0;
      w_done_s = 1'b0;
      w_done_k = 1'b0;
      w_busy   = (r_state != ST_IDLE);
      if (r_state == ST_IDLE && r_rdy) begin
         w_gnt_k = REQ_K && (!REQ_S || KEY_PRIO || !r_last_k);
         w_gnt_s = REQ_S && !w_gnt_k;
      end
      if (r_state == ST_DONE) begin
         w_done_k = r_last_k;
         w_done_s = !r_last_k;
      end
   end

   // datapath: operand capture at grant, one substituted byte per RUN cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rdy    <= 1'b0;
         r_cnt    <= 4'd0;
         r_last_k <= 1'b0;
         r_op     <= '0;
         r_dout_s <= '0;
         r_dout_k <= '0;
      end else begin
         r_rdy <= 1'b1;
         if (w_gnt_s) begin
            r_op     <= DIN_S;
            r_cnt    <= 4'd0;
            r_last_k <= 1'b0;
         end else if (w_gnt_k) begin
            r_op     <= {96'd0, DIN_K};
            r_cnt    <= 4'd0;
            r_last_k <= 1'b1;
         end else if (r_state == ST_RUN_S) begin
            r_dout_s[{r_cnt, 3'b000} +: 8] <= w_sbox_out;
            r_cnt <= r_cnt + 4'd1;
         end else if (r_state == ST_RUN_K) begin
            r_dout_k[{r_cnt[1:0], 3'b000} +: 8] <= w_sbox_out;
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   assign GNT_S  = w_gnt_s;
   assign GNT_K  = w_gnt_k;
   assign DONE_S = w_done_s;
   assign DONE_K = w_done_k;
   assign BUSY   = w_busy;
   assign DOUT_S = r_dout_s;
   assign DOUT_K = r_dout_k;

endmodule

// File: tb/tb_sub_bytes_sched.sv
// Directed bench for sub_bytes_sched: dut0 uses round-robin arbitration,
// dut1 uses fixed key priority. Both share clock and reset.
module tb_sub_bytes_sched;

   localparam logic [127:0] PAT_IN  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] PAT_OUT = 128'h76abd7fe2b670130c56f6bf27b777c63;
   localparam logic [127:0] S_ZERO  = {16{8'h63}};
   localparam logic [31:0]  K_ZERO  = 32'h63636363;
   localparam logic [31:0]  K_IN    = 32'h01020304;
   localparam logic [31:0]  K_OUT   = 32'h7c777bf2;

   logic         CLK = 1'b0;
   logic         RST_N;

   logic         req_s0, req_k0, gnt_s0, gnt_k0, done_s0, done_k0, busy0;
   logic [127:0] din_s0, dout_s0;
   logic [31:0]  din_k0, dout_k0;

   logic         req_s1, req_k1, gnt_s1, gnt_k1, done_s1, done_k1, busy1;
   logic [127:0] din_s1, dout_s1;
   logic [31:0]  din_k1, dout_k1;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   sub_bytes_sched #(.KEY_PRIO(1'b0)) dut0 (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_S(req_s0), .DIN_S(din_s0), .GNT_S(gnt_s0), .DONE_S(done_s0), .DOUT_S(dout_s0),
      .REQ_K(req_k0), .DIN_K(din_k0), .GNT_K(gnt_k0), .DONE_K(done_k0), .DOUT_K(dout_k0),
      .BUSY(busy0)
   );

   sub_bytes_sched #(.KEY_PRIO(1'b1)) dut1 (
      .CLK(CLK), .RST_N(RST_N),
      .REQ_S(req_s1), .DIN_S(din_s1), .GNT_S(gnt_s1), .DONE_S(done_s1), .DOUT_S(dout_s1),
      .REQ_K(req_k1), .DIN_K(din_k1), .GNT_K(gnt_k1), .DONE_K(done_k1), .DOUT_K(dout_k1),
      .BUSY(busy1)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic chk_rst();
      chk("rst_gnt_s0", gnt_s0, 0);   chk("rst_gnt_k0", gnt_k0, 0);
      chk("rst_done_s0", done_s0, 0); chk("rst_done_k0", done_k0, 0);
      chk("rst_busy0", busy0, 0);
      chk("rst_dout_s0", dout_s0, 0); chk("rst_dout_k0", dout_k0, 0);
      chk("rst_gnt_s1", gnt_s1, 0);   chk("rst_gnt_k1", gnt_k1, 0);
      chk("rst_done_s1", done_s1, 0); chk("rst_done_k1", done_k1, 0);
      chk("rst_busy1", busy1, 0);
      chk("rst_dout_s1", dout_s1, 0); chk("rst_dout_k1", dout_k1, 0);
   endtask

   // One state transaction on dut0; the operand is scrambled right after grant.
   task automatic txn_s(input logic [127:0] din, input logic [127:0] exp,
                        input logic [31:0] k_hold);
      int  n;
      bit  seen;
      step();
      req_s0 = 1'b1;
      din_s0 = din;
      #1;
      chk("gnt_s", gnt_s0, 1);
      chk("gnt_k_excl", gnt_k0, 0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         step();
         n++;
         req_s0 = 1'b0;
         din_s0 = ~din;
         #1;
         chk("busy_s", busy0, 1);
         chk("done_k_quiet", done_k0, 0);
         if (done_s0) seen = 1'b1;
      end
      chk("done_s_latency", n, 17);
      chk("dout_s", dout_s0, exp);
      chk("dout_k_unchanged", dout_k0, k_hold);
      step();
      #1;
      chk("idle_after_s", busy0, 0);
      chk("done_s_one_cycle", done_s0, 0);
      chk("dout_s_hold", dout_s0, exp);
   endtask

   task automatic txn_k(input logic [31:0] din, input logic [31:0] exp,
                        input logic [127:0] s_hold);
      int  n;
      bit  seen;
      step();
      req_k0 = 1'b1;
      din_k0 = din;
      #1;
      chk("gnt_k", gnt_k0, 1);
      chk("gnt_s_excl", gnt_s0, 0);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 30) begin
         step();
         n++;
         req_k0 = 1'b0;
         din_k0 = ~din;
         #1;
         chk("busy_k", busy0, 1);
         chk("done_s_quiet", done_s0, 0);
         if (done_k0) seen = 1'b1;
      end
      chk("done_k_latency", n, 5);
      chk("dout_k", dout_k0, exp);
      chk("dout_s_unchanged", dout_s0, s_hold);
      step();
      #1;
      chk("idle_after_k", busy0, 0);
      chk("dout_k_hold", dout_k0, exp);
   endtask

   initial begin
      bit found;

      req_s0 = 0; req_k0 = 0; din_s0 = '0; din_k0 = '0;
      req_s1 = 0; req_k1 = 0; din_s1 = '0; din_k1 = '0;
      RST_N = 1'b1;
      #3 RST_N = 1'b0;
      step();
      chk_rst();

      // both requesters on both instances held high from reset release
      req_s0 = 1; req_k0 = 1; din_s0 = PAT_IN; din_k0 = 32'h0;
      req_s1 = 1; req_k1 = 1; din_s1 = '0;     din_k1 = K_IN;
      step();
      #1;
      chk("rst_req_gnt_k0", gnt_k0, 0);
      chk("rst_req_gnt_s0", gnt_s0, 0);
      chk("rst_req_gnt_k1", gnt_k1, 0);
      RST_N = 1'b1;
      #1;
      chk("release_gnt_k0", gnt_k0, 0);
      chk("release_gnt_k1", gnt_k1, 0);

      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step();
         #1;
         if (gnt_k0) found = 1'b1;
      end
      chk("first_grant_found", found, 1);

      for (int c = 0; c < 48; c++) begin
         if (c > 0) begin
            step();
            if (c == 13) req_k1 = 1'b0;
            if (c == 19) req_s1 = 1'b0;
            #1;
         end
         chk("rr_gnt_k",  gnt_k0,  (c == 0  || c == 24));
         chk("rr_gnt_s",  gnt_s0,  (c == 6  || c == 30));
         chk("rr_done_k", done_k0, (c == 5  || c == 29));
         chk("rr_done_s", done_s0, (c == 23 || c == 47));
         chk("kp_gnt_k",  gnt_k1,  (c == 0  || c == 6  || c == 12));
         chk("kp_gnt_s",  gnt_s1,  (c == 18));
         chk("kp_done_k", done_k1, (c == 5  || c == 11 || c == 17));
         chk("kp_done_s", done_s1, (c == 35));
         if (c == 5 || c == 29)  chk("rr_dout_k", dout_k0, K_ZERO);
         if (c == 23 || c == 47) chk("rr_dout_s", dout_s0, PAT_OUT);
         if (c == 5 || c == 17)  chk("kp_dout_k", dout_k1, K_OUT);
         if (c == 35)            chk("kp_dout_s", dout_s1, S_ZERO);
      end
      step();
      req_s0 = 0; req_k0 = 0;
      #1;
      chk("drop_gnt_s0", gnt_s0, 0);
      chk("drop_gnt_k0", gnt_k0, 0);

      txn_s('0, S_ZERO, K_ZERO);
      txn_s(PAT_IN, PAT_OUT, K_ZERO);
      txn_k(K_IN, K_OUT, PAT_OUT);

      // reset pulse while CNT = 7 in RUN_S
      step();
      req_s0 = 1'b1;
      din_s0 = S_ZERO;
      #1;
      chk("abort_gnt_s", gnt_s0, 1);
      step();
      req_s0 = 1'b0;
      repeat (7) step();
      #1;
      RST_N = 1'b0;
      #1;
      chk_rst();
      step();
      RST_N = 1'b1;
      for (int i = 0; i < 25; i++) begin
         step();
         #1;
         chk("abort_no_done", done_s0, 0);
         chk("abort_idle", busy0, 0);
      end
      txn_s(PAT_IN, PAT_OUT, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
